sync_filter_bank: RTL and testbench

Multi-channel, single-clock input conditioner that is the parametrised successor of the per-demo 2FF/pulse/toggle synchronizers. Each of CH asynchronous inputs passes through a STAGES-deep synchronizer chain and then a runtime-programmable glitch filter. Each channel produces a clean level, one-cycle rise/fall pulses and a sticky event flag. Sits between the ui_in/uio_in pads and any clk-domain consumer logic.

---
 rtl/sync_filter_pkg.sv | 14 +
 rtl/sync_filter_ch.sv | 82 ++++++++
 rtl/sync_filter_bank.sv | 96 +++++++++
 tb/tb_sync_filter_bank.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_filter_pkg.sv
// Shared constants for the sync_filter_bank input conditioner.
package sync_filter_pkg;

  localparam int MIN_STAGES   = 2;
  localparam int EDGE_CNT_W   = 8;
  localparam int EDGE_CNT_MAX = 255;
  localparam int SEL_W        = 4;

  // Synchronizer depths below two offer no metastability protection.
  function automatic int eff_stages(input int stages);
    return (stages < MIN_STAGES) ? MIN_STAGES : stages;
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One conditioner channel: synchronizer chain, glitch filter with a
// stability counter, registered rise/fall pulses and a sticky event flag.
module sync_filter_ch
  import sync_filter_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter int   FILT_W  = 4,
  parameter logic RST_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              async_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              evt_clr,
  output logic              sync_out,
  output logic              filt_out,
  output logic              rise,
  output logic              fall,
  output logic              evt_flag
);

  localparam int N = eff_stages(STAGES);

  logic [N-1:0]      sync_reg;
  logic [FILT_W-1:0] cnt_reg;
  logic              filt_reg;
  logic              rise_reg;
  logic              fall_reg;
  logic              flag_reg;
  logic              mismatch;
  logic              expire;

  // A flip needs filt_len+1 consecutive mismatched cycles; cnt saturates there.
  assign mismatch = sync_reg[N-1] ^ filt_reg;
  assign expire   = mismatch && (cnt_reg >= filt_len);

  // Synchronizer chain keeps shifting regardless of ena.
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= {N{RST_VAL}};
    else     sync_reg <= {sync_reg[N-2:0], async_in};
  end

  // Stability counter, filtered level and one-cycle edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      filt_reg <= RST_VAL;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (ena) begin
        if (expire) begin
          filt_reg <= ~filt_reg;
          cnt_reg  <= '0;
          rise_reg <= ~filt_reg;
          fall_reg <= filt_reg;
        end else if (mismatch) begin
          cnt_reg <= cnt_reg + FILT_W'(1);
        end else begin
          cnt_reg <= '0;
        end
      end
    end
  end

  // Sticky flag follows the registered pulses; a new event beats a clear.
  always_ff @(posedge clk) begin
    if (rst)                       flag_reg <= 1'b0;
    else if (rise_reg || fall_reg) flag_reg <= 1'b1;
    else if (evt_clr)              flag_reg <= 1'b0;
  end

  assign sync_out = sync_reg[N-1];
  assign filt_out = filt_reg;
  assign rise     = rise_reg;
  assign fall     = fall_reg;
  assign evt_flag = flag_reg;

endmodule

// File: rtl/sync_filter_bank.sv
// Multi-channel synchronizer + glitch filter bank.
// Optional build macro SYNC_FILTER_EDGE_COUNT_EN adds per-channel saturating
// rising-edge counters readable through cnt_sel/cnt_out; without it cnt_out
// is tied to zero and the port stays for a uniform pinout.
module sync_filter_bank
  import sync_filter_pkg::*;
#(
  parameter int            CH      = 8,
  parameter int            STAGES  = 2,
  parameter int            FILT_W  = 4,
  parameter logic [CH-1:0] RST_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [CH-1:0]         async_in,
  input  logic [FILT_W-1:0]     filt_len,
  input  logic [CH-1:0]         evt_clr,
  input  logic [SEL_W-1:0]      cnt_sel,
  output logic [CH-1:0]         sync_out,
  output logic [CH-1:0]         filt_out,
  output logic [CH-1:0]         rise,
  output logic [CH-1:0]         fall,
  output logic [CH-1:0]         evt_flags,
  output logic [EDGE_CNT_W-1:0] cnt_out
);

  genvar gi;

  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      sync_filter_ch #(
        .STAGES (STAGES),
        .FILT_W (FILT_W),
        .RST_VAL(RST_VAL[gi])
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .async_in(async_in[gi]),
        .filt_len(filt_len),
        .evt_clr (evt_clr[gi]),
        .sync_out(sync_out[gi]),
        .filt_out(filt_out[gi]),
        .rise    (rise[gi]),
        .fall    (fall[gi]),
        .evt_flag(evt_flags[gi])
      );
    end
  endgenerate

`ifdef SYNC_FILTER_EDGE_COUNT_EN
  // Table padded to the full select range so unused selects read as zero.
  localparam int SEL_N = 1 << SEL_W;

  logic [EDGE_CNT_W-1:0] edge_cnt [SEL_N];
  logic [EDGE_CNT_W-1:0] cnt_out_reg;

  generate
    for (gi = 0; gi < SEL_N; gi++) begin : g_cnt
      if (gi < CH) begin : g_live
        logic [EDGE_CNT_W-1:0] edge_cnt_reg;
        // Saturating rise counter; an increment coinciding with a clear gives 1.
        always_ff @(posedge clk) begin
          if (rst) begin
            edge_cnt_reg <= '0;
          end else if (rise[gi]) begin
            if (evt_clr[gi])
              edge_cnt_reg <= EDGE_CNT_W'(1);
            else if (edge_cnt_reg != EDGE_CNT_W'(EDGE_CNT_MAX))
              edge_cnt_reg <= edge_cnt_reg + EDGE_CNT_W'(1);
          end else if (evt_clr[gi]) begin
            edge_cnt_reg <= '0;
          end
        end
        assign edge_cnt[gi] = edge_cnt_reg;
      end else begin : g_pad
        assign edge_cnt[gi] = '0;
      end
    end
  endgenerate

  // Registered readback mux, one cycle behind cnt_sel.
  always_ff @(posedge clk) begin
    if (rst) cnt_out_reg <= '0;
    else     cnt_out_reg <= edge_cnt[cnt_sel];
  end

  assign cnt_out = cnt_out_reg;
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_sync_filter_bank.sv
// Directed, table-driven bench for sync_filter_bank (CH=8, STAGES=2,
// RST_VAL=8'hA5). Also builds with SYNC_FILTER_EDGE_COUNT_EN defined.
module tb_sync_filter_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] async_in;
  logic [3:0] filt_len;
  logic [7:0] evt_clr;
  logic [3:0] cnt_sel;
  logic [7:0] sync_out;
  logic [7:0] filt_out;
  logic [7:0] rise;
  logic [7:0] fall;
  logic [7:0] evt_flags;
  logic [7:0] cnt_out;

  int checks = 0;
  int errors = 0;

`ifdef SYNC_FILTER_EDGE_COUNT_EN
  localparam logic [7:0] EXP_SAT = 8'd255;
`else
  localparam logic [7:0] EXP_SAT = 8'd0;
`endif

  sync_filter_bank #(
    .CH     (8),
    .STAGES (2),
    .FILT_W (4),
    .RST_VAL(8'hA5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .async_in (async_in),
    .filt_len (filt_len),
    .evt_clr  (evt_clr),
    .cnt_sel  (cnt_sel),
    .sync_out (sync_out),
    .filt_out (filt_out),
    .rise     (rise),
    .fall     (fall),
    .evt_flags(evt_flags),
    .cnt_out  (cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a_in;
    logic [7:0] clr;
    logic [7:0] e_sync;
    logic [7:0] e_filt;
    logic [7:0] e_rise;
    logic [7:0] e_fall;
    logic [7:0] e_flags;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] c,
                              input logic [7:0] s, input logic [7:0] f,
                              input logic [7:0] r, input logic [7:0] fl,
                              input logic [7:0] g);
    vec_t v;
    v.a_in = a; v.clr = c; v.e_sync = s; v.e_filt = f;
    v.e_rise = r; v.e_fall = fl; v.e_flags = g;
    return v;
  endfunction

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int rises;

    // Row i is applied before edge Ei and checked just after it (filt_len=3).
    // Ch0 latency: sampled at E0, flips at E5 -- the 6th edge counting E0.
    tbl[0]  = mk(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[2]  = mk(8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[3]  = mk(8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[4]  = mk(8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[5]  = mk(8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00);
    tbl[6]  = mk(8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
    // Ch1 3-cycle pulse: only three mismatched cycles, rejected.
    tbl[7]  = mk(8'h03, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
    tbl[8]  = mk(8'h03, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01);
    tbl[9]  = mk(8'h03, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01);
    tbl[10] = mk(8'h01, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01);
    tbl[11] = mk(8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
    tbl[12] = mk(8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
    // Ch1 4-cycle pulse: rise at E18, fall four edges later at E22.
    tbl[13] = mk(8'h03, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
    tbl[14] = mk(8'h03, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01);
    tbl[15] = mk(8'h03, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01);
    tbl[16] = mk(8'h03, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01);
    tbl[17] = mk(8'h01, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h01);
    tbl[18] = mk(8'h01, 8'h00, 8'h01, 8'h03, 8'h02, 8'h00, 8'h01);
    tbl[19] = mk(8'h01, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h03);
    tbl[20] = mk(8'h01, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h03);
    tbl[21] = mk(8'h01, 8'h00, 8'h01, 8'h03, 8'h00, 8'h00, 8'h03);
    tbl[22] = mk(8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h03);
    tbl[23] = mk(8'h01, 8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h03);
    tbl[24] = mk(8'h01, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00);

    // Reset state.
    rst = 1'b1; ena = 1'b0; async_in = 8'h00; filt_len = 4'd0;
    evt_clr = 8'h00; cnt_sel = 4'd0;
    step(); step();
    check("reset.sync_out", sync_out, 8'hA5);
    check("reset.filt_out", filt_out, 8'hA5);
    check("reset.rise", rise, 8'h00);
    check("reset.fall", fall, 8'h00);
    check("reset.evt_flags", evt_flags, 8'h00);
    check("reset.cnt_out", cnt_out, 8'h00);
    $display("reset: sync=%h filt=%h flags=%h cnt=%h", sync_out, filt_out, evt_flags, cnt_out);

    // Bring every channel to 0 and clear the resulting flags.
    rst = 1'b0; ena = 1'b1;
    repeat (6) step();
    evt_clr = 8'hFF; step(); evt_clr = 8'h00;
    filt_len = 4'd3;

    for (int i = 0; i < 25; i++) begin
      async_in = tbl[i].a_in;
      evt_clr  = tbl[i].clr;
      step();
      check($sformatf("row%0d.sync", i), sync_out, tbl[i].e_sync);
      check($sformatf("row%0d.filt", i), filt_out, tbl[i].e_filt);
      check($sformatf("row%0d.rise", i), rise, tbl[i].e_rise);
      check($sformatf("row%0d.fall", i), fall, tbl[i].e_fall);
      check($sformatf("row%0d.flags", i), evt_flags, tbl[i].e_flags);
      $display("row %0d: in=%h sync=%h filt=%h rise=%h fall=%h flags=%h",
               i, async_in, sync_out, filt_out, rise, fall, evt_flags);
    end
    evt_clr = 8'h00;

    // ena gating on ch1: two counted cycles, 5 cycles disabled, then 2 more.
    async_in = 8'h03;
    step(); step(); step(); step();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("ena_off%0d.rise", i), rise, 8'h00);
      check($sformatf("ena_off%0d.fall", i), fall, 8'h00);
      check($sformatf("ena_off%0d.filt1", i), filt_out[1], 1'b0);
    end
    ena = 1'b1;
    step();
    check("ena_on1.filt1", filt_out[1], 1'b0);
    step();
    check("ena_on2.filt1", filt_out[1], 1'b1);
    check("ena_on2.rise", rise, 8'h02);
    $display("ena gating: filt=%h rise=%h", filt_out, rise);
    step();
    check("ena_on3.flags", evt_flags, 8'h02);
    evt_clr = 8'hFF; step(); evt_clr = 8'h00;
    check("clr_all.flags", evt_flags, 8'h00);

    // Clear racing a rise on ch2: set wins, a lone clear then drops it.
    filt_len = 4'd0;
    async_in = 8'h07;
    step(); step(); step();
    check("race.rise", rise, 8'h04);
    evt_clr = 8'h04;
    step();
    check("race.flag_kept", evt_flags[2], 1'b1);
    step();
    check("race.flag_cleared", evt_flags[2], 1'b0);
    evt_clr = 8'h00;
    $display("clear race: flags=%h", evt_flags);

    // 300 rising edges on ch3 with filt_len=0.
    rises = 0;
    for (int i = 0; i < 300; i++) begin
      async_in[3] = 1'b1; step(); if (rise[3]) rises++;
      async_in[3] = 1'b0; step(); if (rise[3]) rises++;
    end
    repeat (6) begin step(); if (rise[3]) rises++; end
    check("edges.rise_count", rises, 300);
    cnt_sel = 4'd12; step();
    check("cnt.sel12", cnt_out, 8'h00);
    cnt_sel = 4'd3; step();
    check("cnt.sel3_sat", cnt_out, EXP_SAT);
    $display("edge count: rises=%0d cnt_out=%0d", rises, cnt_out);
    evt_clr = 8'h08; step(); evt_clr = 8'h00; step();
    check("cnt.after_clr", cnt_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
